// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback entry type used by the
// writeback arbiter and its load-result FIFO.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO holding load results waiting for a register-file write slot.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// The caller never pushes while full and never pops while empty.
module wb_load_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state pointers and occupancy; push+pop together leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because the count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write-port front end of the register file: merges ALU results with queued
// load results (ALU has priority, a full load queue forces a drain cycle),
// registers the write port, suppresses x0 writes and tracks pending loads.
module regfile_writeback_arbiter
  import rv_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            load_issue,
  input  logic [AW-1:0]   load_issue_rd,
  input  logic            load_valid,
  input  logic [AW-1:0]   load_rd,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  wb_entry_t       load_entry;
  wb_entry_t       lq_head;
  logic            lq_full;
  logic            lq_empty;
  logic [CW-1:0]   lq_count;
  logic            alu_fire;
  logic            load_fire;
  logic            lq_pop;

  wb_entry_t       sel;
  logic            sel_valid;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Both ready signals come straight from the registered FIFO count, so they
  // never depend combinationally on this cycle's valids.
  assign load_ready = (lq_count != CW'(LQ_DEPTH));
  assign alu_ready  = ~lq_full;

  assign alu_fire   = alu_valid & alu_ready;
  assign load_fire  = load_valid & load_ready;
  // The queue drains only in cycles the ALU does not claim the port.
  assign lq_pop     = ~alu_fire & ~lq_empty;

  assign load_entry = '{rd: load_rd, data: load_data};

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (load_fire),
    .push_entry (load_entry),
    .pop        (lq_pop),
    .head       (lq_head),
    .full       (lq_full),
    .empty      (lq_empty),
    .count      (lq_count)
  );

  // Pick this cycle's single write and form the next write-port values.
  // Address/data hold their last value when nothing is written.
  always_comb begin
    sel_valid = 1'b0;
    sel       = lq_head;
    if (alu_fire) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end else if (lq_pop) begin
      sel_valid = 1'b1;
    end
    rf_we_d    = sel_valid && (sel.rd != '0);
    rf_rd_d    = sel_valid ? sel.rd   : rf_rd_q;
    rf_wdata_d = sel_valid ? sel.data : rf_wdata_q;
  end

  // Pending-load scoreboard: a new issue to r beats a same-cycle pop of r,
  // since that issue belongs to a younger load still in flight.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      assign busy_d[gi] = (load_issue && (load_issue_rd == AW'(gi))) ||
                          (busy_q[gi] && !(lq_pop && (lq_head.rd == AW'(gi))));
    end
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule
